// File: rtl/serial_chunk_adder_if.sv
// Operand/result handshake bundle for serial_chunk_adder.
// SERIAL_ADDER_FLAGS_EN adds the ovf/zero flag signals.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy,
    input  ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy,
    output ovf, zero
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per cycle, LSB first, registered carry.
// Define SERIAL_ADDER_FLAGS_EN to add ovf/zero result flags.
module serial_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $fatal(1, "serial_chunk_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
`endif

  int               base;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   csum;

  // Add the current chunk of the latched operands plus the carry.
  always_comb begin
    base = int'(cnt_q) * CHUNK;
    a_sh = a_q >> base;
    b_sh = b_q >> base;
    a_sl = a_sh[CHUNK-1:0];
    b_sl = b_sh[CHUNK-1:0];
    csum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
  end

  // Sequencing: accept in IDLE, one chunk per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_FLAGS_EN
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: CHUNK] = csum[CHUNK-1:0];
        carry_d = csum[CHUNK];
        if (cnt_q == LAST) begin
          cout_d  = csum[CHUNK];
          cnt_d   = '0;
          state_d = DONE;
`ifdef SERIAL_ADDER_FLAGS_EN
          // carry into the top bit is recovered from its sum bit
          ovf_d  = (a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ csum[CHUNK-1])
                 ^ csum[CHUNK];
          zero_d = (sum_d == '0);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_FLAGS_EN
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_FLAGS_EN
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
`endif

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed scoreboard bench for serial_chunk_adder.
// Sweeps CHUNK = 8, 1 and 32 with three instances.
module tb_serial_chunk_adder;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_chunk_adder_if #(.WIDTH(W)) if8 ();
  serial_chunk_adder_if #(.WIDTH(W)) if1 ();
  serial_chunk_adder_if #(.WIDTH(W)) if32 ();

  serial_chunk_adder #(.WIDTH(W), .CHUNK(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave)
  );
  serial_chunk_adder #(.WIDTH(W), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );
  serial_chunk_adder #(.WIDTH(W), .CHUNK(32)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.slave)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic c);
    exp_t e;
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    e.zero = (r[W-1:0] == '0);
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    @(negedge clk);
    chk("in_ready_idle", 64'(if8.in_ready), 64'd1);
    if8.a = a;
    if8.b = b;
    if8.cin = c;
    if8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if8.in_valid = 1'b0;
    sb.push_back(model(a, b, c));
    if8.a = ~a;
    if8.b = $urandom;
    if8.cin = ~c;
    chk("busy_run", 64'(if8.busy), 64'd1);
    chk("in_ready_run", 64'(if8.in_ready), 64'd0);
  endtask

  task automatic collect(input int lat, input int hold);
    int n;
    exp_t e;
    n = 0;
    while (if8.out_valid !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    e = sb.pop_front();
    chk("sum", 64'(if8.sum), 64'(e.sum));
    chk("cout", 64'(if8.cout), 64'(e.cout));
`ifdef SERIAL_ADDER_FLAGS_EN
    chk("ovf", 64'(if8.ovf), 64'(e.ovf));
    chk("zero", 64'(if8.zero), 64'(e.zero));
`endif
    for (int i = 0; i < hold; i++) begin
      if8.in_valid = ~if8.in_valid;
      if8.a = $urandom;
      if8.b = $urandom;
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(if8.out_valid), 64'd1);
      chk("hold_in_ready", 64'(if8.in_ready), 64'd0);
      chk("hold_sum", 64'(if8.sum), 64'(e.sum));
      chk("hold_cout", 64'(if8.cout), 64'(e.cout));
    end
    if8.in_valid = 1'b1;
    if8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if8.out_ready = 1'b0;
    if8.in_valid = 1'b0;
    chk("done_exit_valid", 64'(if8.out_valid), 64'd0);
    chk("done_exit_ready", 64'(if8.in_ready), 64'd1);
    chk("done_exit_busy", 64'(if8.busy), 64'd0);
  endtask

  initial begin
    int n;
    int lat1;
    int lat32;
    logic [W-1:0] s1, s32;
    logic c1, c32;
    exp_t e;

    rst_n = 1'b0;
    if8.in_valid = 0; if8.a = '0; if8.b = '0; if8.cin = 0;
    if8.out_ready = 0;
    if1.in_valid = 0; if1.a = '0; if1.b = '0; if1.cin = 0;
    if1.out_ready = 1;
    if32.in_valid = 0; if32.a = '0; if32.b = '0; if32.cin = 0;
    if32.out_ready = 1;
    #1;
    chk("rst_in_ready", 64'(if8.in_ready), 64'd1);
    chk("rst_out_valid", 64'(if8.out_valid), 64'd0);
    chk("rst_busy", 64'(if8.busy), 64'd0);
    chk("rst_sum", 64'(if8.sum), 64'd0);
    chk("rst_cout", 64'(if8.cout), 64'd0);
    #16;
    rst_n = 1'b1;

    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    collect(4, 0);

    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    collect(4, 5);

    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("abort_in_ready", 64'(if8.in_ready), 64'd1);
    chk("abort_out_valid", 64'(if8.out_valid), 64'd0);
    chk("abort_busy", 64'(if8.busy), 64'd0);
    chk("abort_sum", 64'(if8.sum), 64'd0);
    chk("abort_cout", 64'(if8.cout), 64'd0);
    #2;
    rst_n = 1'b1;

    issue(32'd5, 32'd3, 1'b0);
    collect(4, 0);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    collect(4, 1);

    @(negedge clk);
    if1.a = 32'h1234_5678;
    if1.b = 32'h9ABC_DEF0;
    if1.cin = 1'b1;
    if1.in_valid = 1'b1;
    if32.a = 32'h1234_5678;
    if32.b = 32'h9ABC_DEF0;
    if32.cin = 1'b1;
    if32.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0;
    if32.in_valid = 1'b0;
    sb.push_back(model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));
    n = 0;
    lat1 = -1;
    lat32 = -1;
    s1 = '0; s32 = '0; c1 = 0; c32 = 0;
    while ((lat1 < 0 || lat32 < 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (lat1 < 0 && if1.out_valid === 1'b1) begin
        lat1 = n; s1 = if1.sum; c1 = if1.cout;
      end
      if (lat32 < 0 && if32.out_valid === 1'b1) begin
        lat32 = n; s32 = if32.sum; c32 = if32.cout;
      end
    end
    e = sb.pop_front();
    chk("c1_latency", 64'(lat1), 64'd32);
    chk("c1_sum", 64'(s1), 64'(e.sum));
    chk("c1_cout", 64'(c1), 64'(e.cout));
    chk("c32_latency", 64'(lat32), 64'd1);
    chk("c32_sum", 64'(s32), 64'(e.sum));
    chk("c32_cout", 64'(c32), 64'(e.cout));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
Multi-cycle, parametrised WIDTH-bit adder for the ALU datapath.
- Processes CHUNK bits per clock, LSB chunk first, using a registered carry between chunks. Trades latency for a narrow carry chain.
- Operands are accepted and results returned over valid/ready handshakes.
- Generalises the single-bit full-adder slice to arbitrary width with sequencing and flow control.

Parameters:
WIDTH, 32, operand and result width in bits.
CHUNK, 8, bits added per cycle. WIDTH % CHUNK must be 0; any other value is an elaboration error (fatal). NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in to bit 0.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  a + b + cin, low WIDTH bits.
cout  output  1  carry-out of bit WIDTH-1.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low asynchronously forces: state = IDLE; in_ready = 1; out_valid = 0; busy = 0; sum = 0; cout = 0; internal carry, chunk counter and operand registers = 0.
- States IDLE, RUN, DONE:
  - IDLE:
    - in_ready = 1.
    - If in_valid is high at a rising edge: latch a, b, cin; set carry register to cin and counter to 0; go to RUN.
  - RUN:
    - in_ready = 0.
    - Each edge adds chunk k: a[k*CHUNK +: CHUNK] + b[same slice] + carry.
    - Writes the CHUNK-bit result into sum[k*CHUNK +: CHUNK], updates the carry register, then increments k.
    - After chunk NCHUNK-1: cout = final carry; go to DONE.
  - DONE:
    - out_valid = 1; sum and cout held stable.
    - When out_ready is high at an edge: go to IDLE and deassert out_valid.
- Latency and throughput:
  - out_valid rises exactly NCHUNK cycles after the accepting edge.
  - Minimum issue interval is NCHUNK+2 cycles (DONE → IDLE → accept).
  - in_ready is high only in IDLE. Operands are never accepted in RUN or DONE, even while a DONE handshake completes.
- Handshake rules:
  - Input changes on a, b, cin during RUN or DONE are ignored; the latched copies are used.
  - in_valid while in_ready = 0 has no effect.
  - out_valid, once high, stays high with a constant result until accepted.
- sum is undefined-but-deterministic while busy in RUN (partially written). Consumers use it only when out_valid is high.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - The carry chain inside one cycle is at most CHUNK bits.
- Boundary conditions:
  - CHUNK = WIDTH: one RUN cycle.
  - CHUNK = 1: pure bit-serial operation.
  - Counter wraps only through the state transition; it never exceeds NCHUNK-1.
- Reset mid-operation:
  - Aborts the operation and discards the partial result.
  - The block is in IDLE with in_ready = 1 on the first edge after rst_n rises.

Optional Feature:
SERIAL_ADDER_FLAGS_EN
- Defined: adds two output ports, updated at the same edge as cout and held through DONE; both reset to 0.
  - ovf (1 bit): signed overflow = carry into bit WIDTH-1 XOR cout.
  - zero (1 bit): sum == 0.
- Undefined: ovf and zero ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle → immediately out_valid = 0, in_ready = 1, busy = 0, sum = 0, cout = 0.
- WIDTH = 32, CHUNK = 8: a = 0xFFFFFFFF, b = 0x00000001, cin = 0 → sum = 0x00000000, cout = 1, out_valid exactly 4 cycles after accept; with flags enabled, zero = 1, ovf = 0.
- a = 0x7FFFFFFF, b = 0x00000001, cin = 0 → sum = 0x80000000, cout = 0, ovf = 1, zero = 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid, toggling in_valid and a/b → sum and cout unchanged, in_ready = 0, no new operation accepted. out_ready = 1 → IDLE next cycle.
- Reset after 2 RUN cycles of a = 0x12345678, b = 0x9ABCDEF0 → outputs cleared. A new op a = 5, b = 3, cin = 0 then completes with sum = 8 in 4 cycles.
- Parameter sweep CHUNK = 1 and CHUNK = 32: a = 0x12345678, b = 0x9ABCDEF0, cin = 1 → sum = 0xACF13569, cout = 0, latency 32 and 1 cycles respectively. WIDTH = 32, CHUNK = 5 → elaboration fails.
